register_file: RTL



---
 rtl/register_file.sv | 62 ++++++
 1 files changed

// File: rtl/register_file.sv
// LEGv8 integer register file: 31 x 64-bit storage plus XZR,
// one synchronous write port and two combinational read ports.
module register_file #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWrite,
  input  logic [ADDR_BITS-1:0] WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic [ADDR_BITS-1:0] ReadRegister1,
  input  logic [ADDR_BITS-1:0] ReadRegister2,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2
);

  localparam int NREG = 2 ** ADDR_BITS;

  logic [NREG-1:0]  en;
  logic [WIDTH-1:0] x [NREG-1];
  logic             en_xzr_unused;

  // Top enable belongs to XZR, which has no storage.
  assign en_xzr_unused = en[NREG-1];

  // One-hot write decode gated by RegWrite.
  always_comb begin
    en = '0;
    for (int r = 0; r < NREG; r++)
      en[r] = RegWrite && (WriteRegister == ADDR_BITS'(r));
  end

  // Enable-gated storage; reset clears every register immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG-1; r++)
        x[r] <= '0;
    end else begin
      for (int r = 0; r < NREG-1; r++)
        if (en[r])
          x[r] <= WriteData;
    end
  end

  // Read port 1 mux; index NREG-1 falls through to zero.
  always_comb begin
    ReadData1 = '0;
    for (int r = 0; r < NREG-1; r++)
      if (ReadRegister1 == ADDR_BITS'(r))
        ReadData1 = x[r];
  end

  // Read port 2 mux; index NREG-1 falls through to zero.
  always_comb begin
    ReadData2 = '0;
    for (int r = 0; r < NREG-1; r++)
      if (ReadRegister2 == ADDR_BITS'(r))
        ReadData2 = x[r];
  end

endmodule
